uart_encoder: RTL
=================

UART_ENCODER -- requirements
Module: uart_encoder

Interface
REQ-001 SHALL have parameter CLK_DIVIDER, default 87, clock cycles per bit period; legal range 2..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-003 SHALL have parameter FIFO_AW, default 2, log2 of transmit FIFO depth (default depth 4).
REQ-004 SHALL have port wb_clk_i  input  1  single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_i  input  8  byte to transmit.
REQ-007 SHALL have port valid_i  input  1  data_i is valid this cycle.
REQ-008 SHALL have port ready_o  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port uart_tx_o  output  1  serial line, idle high, 8N1 (or 8N2).
REQ-010 SHALL have port busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 SHALL have port level_o  output  FIFO_AW+1  current FIFO occupancy.

Function
REQ-012 SHALL accept a byte into the FIFO on each cycle where valid_i and ready_o are both high; valid_i with ready_o low SHALL have no effect.
REQ-013 SHALL drive ready_o = (level_o < 2^FIFO_AW), computed from registered state only; no combinational path from valid_i to ready_o.
REQ-014 SHALL update level_o one cycle after a push or pop; a simultaneous push and pop SHALL leave level_o unchanged.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: uart_tx_o high; if the FIFO is non-empty, SHALL pop the head byte into a shift register and enter START on the next edge.
REQ-017 Latency: a byte pushed into an empty FIFO while in IDLE SHALL produce the uart_tx_o falling edge exactly 2 cycles after the push edge.
REQ-018 START: uart_tx_o low for exactly CLK_DIVIDER cycles, then enter DATA.
REQ-019 DATA: SHALL shift out 8 bits LSB first, each held exactly CLK_DIVIDER cycles, tracked by a 3-bit bit counter; after bit 7, enter STOP.
REQ-020 STOP: uart_tx_o high for exactly STOP_BITS*CLK_DIVIDER cycles.
REQ-021 At the end of STOP with the FIFO non-empty, SHALL pop the next byte and enter START directly, with no idle cycle; a full frame is therefore exactly (9+STOP_BITS)*CLK_DIVIDER cycles.
REQ-022 At the end of STOP with the FIFO empty, SHALL enter IDLE.
REQ-023 The bit-period counter SHALL be ceil(log2(CLK_DIVIDER)) bits wide, count 0..CLK_DIVIDER-1, and wrap to 0 on each bit boundary.
REQ-024 uart_tx_o SHALL be driven directly from a flip-flop (glitch-free).
REQ-025 busy_o SHALL be high whenever state != IDLE or level_o != 0.
REQ-026 Bytes pushed during a frame SHALL be queued and never corrupt the frame in flight.
REQ-027 FIFO read and write pointers SHALL wrap modulo 2^FIFO_AW.

Reset
REQ-028 On wb_rst_i high at a clock edge, SHALL enter IDLE, clear the FIFO and all counters, and set uart_tx_o=1, ready_o=1, busy_o=0, level_o=0 from the next cycle.
REQ-029 Reset asserted mid-frame SHALL abort the frame: uart_tx_o high the following cycle; queued bytes are discarded.
REQ-030 A push coincident with wb_rst_i high SHALL be discarded.

Verification
REQ-031 CLK_DIVIDER=4, STOP_BITS=1; push 0x55 while idle -> tx low at push+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, then high for 4 cycles; busy_o low after 40 frame cycles.
REQ-032 CLK_DIVIDER=4; push 0xA3 then 0x0F back-to-back -> two frames with the second start bit immediately after the first stop bit (80 contiguous cycles); decoded bytes A3, 0F.
REQ-033 FIFO_AW=2; hold valid_i high with 6 distinct bytes while a frame is active -> ready_o low once level_o=4; no byte lost or duplicated; all 6 decoded in order.
REQ-034 Assert wb_rst_i for 1 cycle during DATA bit 3 of 0xFF with 2 bytes queued -> uart_tx_o=1 next cycle, level_o=0, busy_o=0; no further frames emitted.
REQ-035 STOP_BITS=2, CLK_DIVIDER=8; push 0x00 twice -> each stop period 16 cycles high; frame period 88 cycles.
REQ-036 Loopback with the existing uart_decoder at CLK_DIVIDER=87 (100 MHz clock) -> 256 sequential bytes 0x00..0xFF decoded without error.

Source files
------------

// File: rtl/uart_encoder.sv
// uart_encoder: FIFO-buffered 8N1/8N2 UART transmitter with registered serial output.
module uart_encoder #(
  parameter int CLK_DIVIDER = 87,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_AW     = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [7:0]         data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               uart_tx_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   level_o
);
  localparam int CW    = $clog2(CLK_DIVIDER);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [CW-1:0]      cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               tx, push, pop, last, stop_done, has_data;
  assign has_data  = level != '0;
  assign ready_o   = level < (FIFO_AW+1)'(DEPTH);
  assign push      = valid_i & ready_o;
  assign last      = cnt == CW'(CLK_DIVIDER - 1);
  assign stop_done = state == STOP && last && bit_cnt == 3'(STOP_BITS - 1);
  assign pop       = has_data && (state == IDLE || stop_done);
  assign busy_o    = state != IDLE || has_data;
  assign level_o   = level;
  assign uart_tx_o = tx;
  always_ff @(posedge wb_clk_i)
    if (push && !wb_rst_i) mem[wr_ptr] <= data_i;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      level  <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end
  // tx is the line value of the state held during the previous cycle, so it lags state by one
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      tx      <= state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
      cnt     <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      bit_cnt <= ((state == DATA || state == STOP) && last) ? (stop_done ? 3'd0 : bit_cnt + 3'd1) : bit_cnt;
      shreg   <= pop ? mem[rd_ptr] : (state == DATA && last) ? shreg >> 1 : shreg;
      case (state)
        IDLE:  if (has_data) state <= START;
        START: if (last) state <= DATA;
        DATA:  if (last && bit_cnt == 3'd7) state <= STOP;
        STOP:  if (stop_done) state <= has_data ? START : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
